// File: rtl/sr_input_conditioner.sv
// Button front end: sync, debounce and arbitrate s/r drive for an SR flop.
// SR_INPUT_COND_HOLD_EN selects level (hold) drive instead of pulses.
module sr_input_conditioner #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_reset,
  output logic s,
  output logic r,
  output logic set_stable,
  output logic reset_stable,
  output logic conflict
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  // bit 0 is the set channel, bit 1 the reset channel
  logic [1:0]            btn;
  logic [1:0]            sync1;
  logic [1:0]            sync2;
  logic [1:0]            stab;
  logic [1:0][CNT_W-1:0] cnt;

  assign btn = {btn_reset, btn_set};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      stab  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stab[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stab[i] <= ~stab[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign set_stable   = stab[0];
  assign reset_stable = stab[1];

`ifdef SR_INPUT_COND_HOLD_EN

  logic s_q;
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= 1'b0;
      r_q <= 1'b0;
    end else begin
      s_q <= stab[0] & ~stab[1];
      r_q <= stab[1];
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = stab[0] & stab[1];

`else

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SET  = 2'b01,
    RST  = 2'b10
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] stab_q;
  logic       sreq;
  logic       rreq;
  logic       pend_s;
  logic       pend_r;

  assign sreq = stab[0] & ~stab_q[0];
  assign rreq = stab[1] & ~stab_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      stab_q <= '0;
      pend_s <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      state  <= nxt;
      stab_q <= stab;
      pend_s <= (state == RST) & sreq & ~rreq;
      pend_r <= (state == SET) & rreq;
    end
  end

  // a simultaneous set request is dropped so reset always wins
  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE: begin
        if (rreq)      nxt = RST;
        else if (sreq) nxt = SET;
      end
      SET: begin
        if (rreq | pend_r) nxt = RST;
      end
      RST: begin
        if ((sreq | pend_s) & ~rreq) nxt = SET;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    s        = (state == SET);
    r        = (state == RST);
    conflict = sreq & rreq;
  end

`endif

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Bench for sr_input_conditioner: directed plan steps plus random bouncy
// buttons checked against a window-based reference model.
module tb_sr_input_conditioner;

  localparam int DB = 4;

  logic clk;
  logic rst;
  logic btn_set;
  logic btn_reset;
  logic s;
  logic r;
  logic set_stable;
  logic reset_stable;
  logic conflict;

  int errors = 0;
  int checks = 0;

  sr_input_conditioner #(.DB_CYCLES(DB), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .btn_set(btn_set),
    .btn_reset(btn_reset),
    .s(s),
    .r(r),
    .set_stable(set_stable),
    .reset_stable(reset_stable),
    .conflict(conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  bit m_s1[2];
  bit m_s2[2];
  bit m_st[2];
  bit m_prev[2];
  bit hq0[$];
  bit hq1[$];
  int m_drive;   // 0 none, 1 s pulse, 2 r pulse
  bit m_hs;
  bit m_hr;

  // true when the last DB debouncer samples all disagree with st
  function automatic bit all_diff(input bit q[$], input bit st);
    if (q.size() < DB) return 1'b0;
    for (int k = 0; k < q.size(); k++)
      if (q[k] == st) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit sreq;
    bit rreq;
    bit b[2];
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0;
        m_st[i] = 0; m_prev[i] = 0;
      end
      hq0.delete();
      hq1.delete();
      m_drive = 0;
      m_hs = 0;
      m_hr = 0;
    end else begin
      sreq = m_st[0] & ~m_prev[0];
      rreq = m_st[1] & ~m_prev[1];
      if (rreq && m_drive != 2)
        m_drive = 2;
      else if (sreq && !rreq && m_drive != 1)
        m_drive = 1;
      else
        m_drive = 0;
      m_hs = m_st[0] & ~m_st[1];
      m_hr = m_st[1];
      hq0.push_back(m_s2[0]);
      hq1.push_back(m_s2[1]);
      if (hq0.size() > DB) void'(hq0.pop_front());
      if (hq1.size() > DB) void'(hq1.pop_front());
      m_prev[0] = m_st[0];
      m_prev[1] = m_st[1];
      if (all_diff(hq0, m_st[0])) begin
        m_st[0] = ~m_st[0];
        hq0.delete();
      end
      if (all_diff(hq1, m_st[1])) begin
        m_st[1] = ~m_st[1];
        hq1.delete();
      end
      b[0] = btn_set;
      b[1] = btn_reset;
      for (int i = 0; i < 2; i++) begin
        m_s2[i] = m_s1[i];
        m_s1[i] = b[i];
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic es;
    logic er;
    logic ec;
`ifdef SR_INPUT_COND_HOLD_EN
    es = m_hs;
    er = m_hr;
    ec = m_st[0] & m_st[1];
`else
    es = (m_drive == 1);
    er = (m_drive == 2);
    ec = (m_st[0] & ~m_prev[0]) & (m_st[1] & ~m_prev[1]);
`endif
    chk("model_s", s, es);
    chk("model_r", r, er);
    chk("model_set_stable", set_stable, m_st[0]);
    chk("model_reset_stable", reset_stable, m_st[1]);
    chk("model_conflict", conflict, ec);
    chk("s_and_r", s & r, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    btn_set = 0;
    btn_reset = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  int hold_s;
  int hold_r;

  initial begin
    rst = 1;
    btn_set = 1;
    btn_reset = 1;
    hold_s = 0;
    hold_r = 0;

    // reset with both buttons held
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_s", s, 1'b0);
      chk("t1_r", r, 1'b0);
      chk("t1_conflict", conflict, 1'b0);
      chk("t1_set_stable", set_stable, 1'b0);
      chk("t1_reset_stable", reset_stable, 1'b0);
    end
    btn_set = 0;
    btn_reset = 0;
    step();
    rst = 0;
    idle(4);

`ifndef SR_INPUT_COND_HOLD_EN
    // clean set press
    btn_set = 1;
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("t2_set_stable", set_stable, j >= 6);
      chk("t2_s", s, j == 7);
      chk("t2_r", r, 1'b0);
    end
    idle(12);

    // bouncy reset press
    for (int i = 0; i < 12; i++) begin
      btn_reset = ((i / 2) % 2 == 0);
      step();
      chk("t3_bounce_stable", reset_stable, 1'b0);
      chk("t3_bounce_r", r, 1'b0);
    end
    btn_reset = 1;
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("t3_reset_stable", reset_stable, j >= 6);
      chk("t3_r", r, j == 7);
    end
    idle(12);

    // simultaneous presses
    btn_set = 1;
    btn_reset = 1;
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("t4_conflict", conflict, j == 6);
      chk("t4_r", r, j == 7);
      chk("t4_s", s, 1'b0);
    end
    idle(12);

    // reset press lands while s is being driven
    btn_set = 1;
    step();
    btn_reset = 1;
    for (int j = 2; j <= 11; j++) begin
      step();
      chk("t5_s", s, j == 7);
      chk("t5_r", r, j == 8);
      chk("t5_conflict", conflict, 1'b0);
    end
    idle(12);

    // reset mid-debounce with the button held
    btn_set = 1;
    for (int k = 0; k < 4; k++) step();
    rst = 1;
    step();
    chk("t7_rst_stable", set_stable, 1'b0);
    rst = 0;
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("t7_set_stable", set_stable, j >= 6);
      chk("t7_s", s, j == 7);
    end
    idle(12);
`else
    // both held in level mode
    btn_set = 1;
    btn_reset = 1;
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("t6_conflict", conflict, j >= 6);
      chk("t6_r", r, j >= 7);
      chk("t6_s", s, 1'b0);
    end
    idle(12);
`endif

    // random bouncy buttons with occasional resets
    for (int n = 0; n < 4000; n++) begin
      if (hold_s == 0) begin
        btn_set = 1'($urandom_range(0, 1));
        hold_s = $urandom_range(1, 12);
      end
      if (hold_r == 0) begin
        btn_reset = 1'($urandom_range(0, 1));
        hold_r = $urandom_range(1, 12);
      end
      hold_s--;
      hold_r--;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
